spi_pkt_receiver: RTL

SPI_PKT_RECEIVER -- requirements
Module: spi_pkt_receiver

---
 rtl/spi_pkt_receiver_pkg.sv | 29 ++
 rtl/spi_pkt_receiver_word_fifo.sv | 68 ++++++
 rtl/spi_pkt_receiver.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkt_receiver_pkg.sv
// Shared definitions for the SPI packet receiver: receiver states, packet
// header field offsets, TPP opcodes and a saturating counter helper.
package spi_pkt_receiver_pkg;

    // Receiver control states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RECV    = 3'd1,
        ST_FLUSH   = 3'd2,
        ST_HANDOFF = 3'd3,
        ST_DROP    = 3'd4
    } rxState_e;

    // Word offsets of the packet header fields
    localparam int OPCODE_IDX = 0;
    localparam int LEN_IDX    = 1;

    // TPP opcodes carried in word 0 of a packet
    localparam logic [31:0] TPP_OP_NOP   = 32'h0000_0000;
    localparam logic [31:0] TPP_OP_WRITE = 32'h0000_0001;
    localparam logic [31:0] TPP_OP_READ  = 32'h0000_0002;
    localparam logic [31:0] TPP_OP_EXEC  = 32'h0000_0003;

    // Increment an 8-bit counter, holding at its maximum value
    function automatic logic [7:0] satInc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/spi_pkt_receiver_word_fifo.sv
// Small synchronous word FIFO with show-ahead read data, a synchronous clear
// and full/empty flags. DEPTH must be a power of two, at least 2.
module word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] pushData_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] popData_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] storage_q [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [AW:0]      count_q;
    logic             pushOk;
    logic             popOk;

    // Flags, head-of-queue data and the qualified push/pop strobes
    always_comb begin
        full_o    = (count_q == (AW+1)'(DEPTH));
        empty_o   = (count_q == '0);
        popData_o = storage_q[rdPtr_q];
        pushOk    = push_i && !full_o;
        popOk     = pop_i && !empty_o;
    end

    // Pointer and occupancy tracking; a simultaneous push and pop leaves the count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else if (clear_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (pushOk) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (popOk) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({pushOk, popOk})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Word storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (pushOk && !clear_i) begin
            storage_q[wrPtr_q] <= pushData_i;
        end
    end

endmodule

// File: rtl/spi_pkt_receiver.sv
// SPI packet receiver: assembles little-endian words from an SPI byte stream,
// buffers them in a word FIFO, writes them to a packet buffer in memory and
// hands complete packets to a downstream parser. Malformed, oversize or
// overflowing packets are dropped and counted.
module spi_pkt_receiver
    import spi_pkt_receiver_pkg::*;
#(
    parameter int ADDR_SIZE  = 23,
    parameter int BUF_BASE   = 0,
    parameter int BUF_WORDS  = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_frame,
    input  logic [7:0]           rx_byte,
    input  logic                 rx_valid,
    output logic [ADDR_SIZE-1:0] mem_ptr,
    output logic [31:0]          mem_data_store,
    output logic                 mem_w_en,
    input  logic                 mem_done,
    output logic                 pkt_avail,
    output logic [ADDR_SIZE-1:0] pkt_region_begin,
    output logic [ADDR_SIZE-1:0] pkt_region_end,
    input  logic                 dpr_done,
    output logic [7:0]           err_count
);

    rxState_e              state_q;
    logic [1:0]            byteCnt_q;
    logic [23:0]           assembly_q;
    logic                  pushValid_q;
    logic [31:0]           pushData_q;
    logic [31:0]           wordIdx_q;
    logic [31:0]           totalWords_q;
    logic [31:0]           writeIdx_q;
    logic                  memWEn_q;
    logic [ADDR_SIZE-1:0]  memPtr_q;
    logic [31:0]           memData_q;
    logic                  pktAvail_q;
    logic [ADDR_SIZE-1:0]  regionEnd_q;
    logic [7:0]            errCount_q;
    logic                  ignoreFrame_q;

    logic                  fifoPush_d;
    logic                  fifoPop_d;
    logic                  fifoClear_d;
    logic                  writeStart_d;
    logic                  lenOversize_d;
    logic [31:0]           fifoRdata;
    logic                  fifoFull;
    logic                  fifoEmpty;

    word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_word_fifo (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (fifoClear_d),
        .push_i     (fifoPush_d),
        .pushData_i (pushData_q),
        .pop_i      (fifoPop_d),
        .popData_o  (fifoRdata),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty)
    );

    // FIFO and write-engine strobes derived from the registered state
    always_comb begin
        fifoPush_d    = pushValid_q && (state_q == ST_RECV);
        fifoClear_d   = (state_q == ST_DROP);
        fifoPop_d     = memWEn_q && mem_done;
        writeStart_d  = !memWEn_q && !fifoEmpty &&
                        ((state_q == ST_RECV) || (state_q == ST_FLUSH));
        lenOversize_d = ({1'b0, pushData_q} + 33'd2) > 33'(BUF_WORDS);
    end

    // Receive FSM, byte assembly, write engine and error accounting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            byteCnt_q     <= '0;
            assembly_q    <= '0;
            pushValid_q   <= 1'b0;
            pushData_q    <= '0;
            wordIdx_q     <= '0;
            totalWords_q  <= '0;
            writeIdx_q    <= '0;
            memWEn_q      <= 1'b0;
            memPtr_q      <= '0;
            memData_q     <= '0;
            pktAvail_q    <= 1'b0;
            regionEnd_q   <= '0;
            errCount_q    <= '0;
            ignoreFrame_q <= 1'b0;
        end else begin
            pushValid_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (rx_valid && rx_frame && !ignoreFrame_q) begin
                        state_q          <= ST_RECV;
                        assembly_q       <= {16'd0, rx_byte};
                        byteCnt_q        <= 2'd1;
                        wordIdx_q        <= '0;
                        writeIdx_q       <= '0;
                    end
                end

                ST_RECV: begin
                    if (rx_valid && rx_frame) begin
                        if (fifoFull) begin
                            state_q    <= ST_DROP;
                            errCount_q <= satInc8(errCount_q);
                        end else begin
                            byteCnt_q <= byteCnt_q + 2'd1;
                            case (byteCnt_q)
                                2'd0: assembly_q[7:0]   <= rx_byte;
                                2'd1: assembly_q[15:8]  <= rx_byte;
                                2'd2: assembly_q[23:16] <= rx_byte;
                                default: begin
                                    pushData_q  <= {rx_byte, assembly_q};
                                    pushValid_q <= 1'b1;
                                end
                            endcase
                        end
                    end

                    if (pushValid_q) begin
                        wordIdx_q <= wordIdx_q + 32'd1;
                        if (wordIdx_q == 32'(LEN_IDX)) begin
                            totalWords_q <= pushData_q + 32'd2;
                            if (lenOversize_d) begin
                                state_q    <= ST_DROP;
                                errCount_q <= satInc8(errCount_q);
                            end else if (pushData_q == 32'd0) begin
                                state_q <= ST_FLUSH;
                            end
                        end else if ((wordIdx_q > 32'(LEN_IDX)) &&
                                     (wordIdx_q + 32'd1 == totalWords_q)) begin
                            state_q <= ST_FLUSH;
                        end
                    end else if (!rx_frame) begin
                        state_q    <= ST_DROP;
                        errCount_q <= satInc8(errCount_q);
                    end
                end

                ST_FLUSH: begin
                    if (fifoEmpty && !memWEn_q) begin
                        state_q     <= ST_HANDOFF;
                        pktAvail_q  <= 1'b1;
                        regionEnd_q <= ADDR_SIZE'(32'(BUF_BASE) + totalWords_q - 32'd1);
                    end
                end

                ST_HANDOFF: begin
                    if (dpr_done && pktAvail_q) begin
                        pktAvail_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end

                ST_DROP: begin
                    if (!rx_frame && !memWEn_q) begin
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            if (!rx_frame) begin
                ignoreFrame_q <= 1'b0;
            end else if (rx_valid && !ignoreFrame_q &&
                         ((state_q == ST_FLUSH) || (state_q == ST_HANDOFF))) begin
                ignoreFrame_q <= 1'b1;
                errCount_q    <= satInc8(errCount_q);
            end

            if (writeStart_d) begin
                memWEn_q  <= 1'b1;
                memPtr_q  <= ADDR_SIZE'(32'(BUF_BASE) + writeIdx_q);
                memData_q <= fifoRdata;
            end else if (fifoPop_d) begin
                memWEn_q   <= 1'b0;
                writeIdx_q <= writeIdx_q + 32'd1;
            end
        end
    end

    assign mem_ptr          = memPtr_q;
    assign mem_data_store   = memData_q;
    assign mem_w_en         = memWEn_q;
    assign pkt_avail        = pktAvail_q;
    assign pkt_region_begin = ADDR_SIZE'(BUF_BASE);
    assign pkt_region_end   = regionEnd_q;
    assign err_count        = errCount_q;

endmodule
